soc_system_sysid_ext: RTL
=========================

SOC_SYSTEM_SYSID_EXT -- requirements
Module: soc_system_sysid_ext

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'hACD5_1402, system ID word.
REQ-002 SHALL have parameter TIMESTAMP, default 32'h5616_AD0D, build timestamp word.
REQ-003 SHALL have parameter NUM_USER_WORDS, default 2, legal range 0..8, count of read-only user words.
REQ-004 SHALL have parameter USER_WORDS, default all zero, NUM_USER_WORDS*32 bits, user word i in bits [32i+31:32i].
REQ-005 SHALL have parameter READ_LATENCY, default 1, legal range 1..3, cycles from read to readdatavalid.
REQ-006 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port address, input, 4, word address.
REQ-009 SHALL have port read, input, 1, read strobe.
REQ-010 SHALL have port write, input, 1, write strobe.
REQ-011 SHALL have port writedata, input, 32, write data.
REQ-012 SHALL have port byteenable, input, 4, write byte lanes.
REQ-013 SHALL have port readdata, output, 32, read data.
REQ-014 SHALL have port readdatavalid, output, 1, readdata qualifier.

Function
REQ-015 SHALL use this word map: 0 ID, 1 TIMESTAMP, 2 SCRATCH (RW), 3 CTRL (RW), 4 UPTIME_LO, 5 UPTIME_HI, 6 CAPS, 7 reserved, 8..15 USER[0..7].
REQ-016 SHALL return 0 for word 7, for USER[i] with i >= NUM_USER_WORDS, and for reads of writes-only fields; writes to read-only words SHALL be ignored.
REQ-017 SHALL accept a read every cycle (no waitrequest) and assert readdatavalid for one cycle exactly READ_LATENCY cycles after each accepted read, preserving order for back-to-back reads.
REQ-018 SHALL drive readdata to 0 whenever readdatavalid is low.
REQ-019 SHALL apply writes on the same clock edge, per-byte under byteenable, to SCRATCH and CTRL.
REQ-020 CTRL bit0 EN SHALL enable the 64-bit uptime counter; bit1 CLR SHALL be write-1 self-clearing (reads 0); bits 31:2 SHALL read 0.
REQ-021 The uptime counter SHALL increment by 1 per cycle while EN=1 and wrap from 2^64-1 to 0 without flag.
REQ-022 CLR write SHALL load counter 0 on that edge; CLR with EN=1 SHALL resume counting from 0 the next cycle; CLR wins over increment.
REQ-023 A read of UPTIME_LO SHALL return counter[31:0] sampled at the read-accept edge and latch counter[63:32] from the same edge into a HI shadow.
REQ-024 A read of UPTIME_HI SHALL return the HI shadow, not the live counter.
REQ-025 CAPS SHALL read {16'h0001 version, 8'(NUM_USER_WORDS), 6'b0, 2'(READ_LATENCY)}.
REQ-026 Read and write in the same cycle SHALL both be accepted; the read SHALL return the pre-write value.

Reset
REQ-027 On reset, readdatavalid=0, readdata=0, SCRATCH=0, CTRL EN=1, counter=0, HI shadow=0.
REQ-028 Reset SHALL flush the read pipeline; reads in flight SHALL produce no readdatavalid.
REQ-029 Reads and writes presented while reset is high SHALL be ignored.

Structure
REQ-030 Word offsets, CAPS version constant and CTRL bit positions SHALL live in package soc_system_sysid_pkg.
REQ-031 The counter, CLR/EN logic and HI shadow SHALL form sub-module soc_system_sysid_uptime.
REQ-032 The read pipeline SHALL be a READ_LATENCY-deep valid/data shift register; parameter checks SHALL fail elaboration when out of range.

Verification
REQ-033 After reset, read words 0,1,6 at latency 2 -> 32'hACD5_1402, 32'h5616_AD0D, 32'h0001_0202, each valid exactly 2 cycles after its read.
REQ-034 Write SCRATCH 32'hDEAD_BEEF with byteenable 4'b0101 after reset -> read returns 32'h00AD_00EF.
REQ-035 Preload counter to 64'h0000_0000_FFFF_FFFE, read UPTIME_LO then UPTIME_HI in cycles 0 and 1 -> 32'hFFFF_FFFE then 32'h0, with no tearing.
REQ-036 Write CTRL 32'h3 -> counter 0 the next cycle, then +1 per cycle; write 32'h0 -> counter frozen across 10 cycles.
REQ-037 Issue 3 back-to-back reads, assert reset in the cycle after the last -> no readdatavalid afterwards, readdata=0.
REQ-038 With NUM_USER_WORDS=2, read words 9 and 10 -> USER[1], then 0; same-cycle read and write of SCRATCH -> old value returned.

Source files
------------

// File: rtl/soc_system_sysid_pkg.sv
// Register map, CAPS version and CTRL bit layout shared by the sysid block.
// Also holds the read-pipeline beat type and the byte-lane merge helper.
package soc_system_sysid_pkg;

    localparam logic [3:0] ADDR_ID        = 4'd0;
    localparam logic [3:0] ADDR_TIMESTAMP = 4'd1;
    localparam logic [3:0] ADDR_SCRATCH   = 4'd2;
    localparam logic [3:0] ADDR_CTRL      = 4'd3;
    localparam logic [3:0] ADDR_UPTIME_LO = 4'd4;
    localparam logic [3:0] ADDR_UPTIME_HI = 4'd5;
    localparam logic [3:0] ADDR_CAPS      = 4'd6;
    localparam logic [3:0] ADDR_RSVD      = 4'd7;
    localparam logic [3:0] ADDR_USER0     = 4'd8;

    localparam logic [15:0] CAPS_VERSION = 16'h0001;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    localparam int MAX_USER_WORDS   = 8;
    localparam int MAX_READ_LATENCY = 3;

    typedef struct packed {
        logic        vld;
        logic [31:0] dat;
    } rd_beat_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_dat,
                                                input logic [31:0] new_dat,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_dat;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_dat[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/soc_system_sysid_uptime.sv
// 64-bit uptime counter with EN/CLR control and a HI shadow latched on LO reads.
// Updates on the same edge as the qualifying write/read; no backpressure.
module soc_system_sysid_uptime
    import soc_system_sysid_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_wr,
    input  logic        ctrl_en_dat,
    input  logic        ctrl_clr_dat,
    input  logic        lo_rd,
    output logic        en,
    output logic [31:0] cnt_lo,
    output logic [31:0] hi_shadow
);

    logic        en_q, en_d;
    logic [63:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;

    always_comb begin
        en_d  = en_q;
        cnt_d = cnt_q;
        hi_d  = hi_q;
        if (ctrl_wr) begin
            en_d = ctrl_en_dat;
        end
        // Clear takes priority; the increment uses EN as it was before this edge.
        if (ctrl_wr && ctrl_clr_dat) begin
            cnt_d = '0;
        end else if (en_q) begin
            cnt_d = cnt_q + 64'd1;
        end
        if (lo_rd) begin
            hi_d = cnt_q[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q  <= 1'b1;
            cnt_q <= '0;
            hi_q  <= '0;
        end else begin
            en_q  <= en_d;
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
        end
    end

    assign en        = en_q;
    assign cnt_lo    = cnt_q[31:0];
    assign hi_shadow = hi_q;

endmodule

// File: rtl/soc_system_sysid_ext.sv
// System ID / timestamp / scratch / uptime register block; reads return after READ_LATENCY cycles.
// Accepts a read and a write every cycle with no waitrequest; reads see pre-write values.
module soc_system_sysid_ext
    import soc_system_sysid_pkg::*;
#(
    parameter logic [31:0] ID_VALUE       = 32'hACD5_1402,
    parameter logic [31:0] TIMESTAMP      = 32'h5616_AD0D,
    parameter int          NUM_USER_WORDS = 2,
    parameter logic [((NUM_USER_WORDS > 0) ? NUM_USER_WORDS : 1)*32-1:0] USER_WORDS = '0,
    parameter int          READ_LATENCY   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    if (NUM_USER_WORDS < 0 || NUM_USER_WORDS > MAX_USER_WORDS) begin : g_bad_user_words
        $error("NUM_USER_WORDS must be in 0..8");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_read_latency
        $error("READ_LATENCY must be in 1..3");
    end

    logic        rd_acc, wr_acc;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] rd_mux;
    logic        up_en;
    logic [31:0] up_cnt_lo, up_hi;
    logic [31:0] user_arr [MAX_USER_WORDS];
    rd_beat_t    pipe_q [READ_LATENCY];
    rd_beat_t    pipe_d [READ_LATENCY];

    assign rd_acc = read  && !reset;
    assign wr_acc = write && !reset;

    for (genvar g = 0; g < MAX_USER_WORDS; g++) begin : g_user
        if (g < NUM_USER_WORDS) begin : g_used
            assign user_arr[g] = USER_WORDS[32*g +: 32];
        end else begin : g_unused
            assign user_arr[g] = '0;
        end
    end

    soc_system_sysid_uptime u_uptime (
        .clk          (clock),
        .reset        (reset),
        .ctrl_wr      (wr_acc && (address == ADDR_CTRL) && byteenable[0]),
        .ctrl_en_dat  (writedata[CTRL_EN_BIT]),
        .ctrl_clr_dat (writedata[CTRL_CLR_BIT]),
        .lo_rd        (rd_acc && (address == ADDR_UPTIME_LO)),
        .en           (up_en),
        .cnt_lo       (up_cnt_lo),
        .hi_shadow    (up_hi)
    );

    always_comb begin
        scratch_d = scratch_q;
        if (wr_acc && (address == ADDR_SCRATCH)) begin
            scratch_d = merge_bytes(scratch_q, writedata, byteenable);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_ID:        rd_mux = ID_VALUE;
            ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            ADDR_SCRATCH:   rd_mux = scratch_q;
            ADDR_CTRL:      rd_mux[CTRL_EN_BIT] = up_en;
            ADDR_UPTIME_LO: rd_mux = up_cnt_lo;
            ADDR_UPTIME_HI: rd_mux = up_hi;
            ADDR_CAPS:      rd_mux = {CAPS_VERSION, 8'(NUM_USER_WORDS), 6'b0, 2'(READ_LATENCY)};
            ADDR_RSVD:      rd_mux = '0;
            default:        rd_mux = user_arr[3'(address - ADDR_USER0)];
        endcase
    end

    // Idle beats carry zero data so readdata is 0 whenever readdatavalid is low.
    always_comb begin
        for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_d[i] = '0;
        end
        pipe_d[0].vld = rd_acc;
        pipe_d[0].dat = rd_acc ? rd_mux : 32'h0;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scratch_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            scratch_q <= scratch_d;
            pipe_q    <= pipe_d;
        end
    end

    assign readdatavalid = pipe_q[READ_LATENCY-1].vld;
    assign readdata      = pipe_q[READ_LATENCY-1].dat;

endmodule
